// File: rtl/snitch_icache_data_ctrl.sv
// Data SRAM access controller for the instruction cache.
// Shares one SRAM port between lookup reads and refill writes. Read lines
// come back over a valid/ready port, and a one-entry hold register absorbs
// back-pressure. Refills normally win the port. A starvation counter forces
// a waiting lookup through after MAX_STALL consecutive refill wins.
module snitch_icache_data_ctrl #(
    parameter int unsigned WAY_COUNT  = 4,
    parameter int unsigned LINE_COUNT = 128,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned MAX_STALL  = 4,
    localparam int unsigned AW = $clog2(LINE_COUNT),
    localparam int unsigned WW = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 lookup_valid_i,
    output logic                                 lookup_ready_o,
    input  logic [AW-1:0]                        lookup_addr_i,
    input  logic [WW-1:0]                        lookup_way_i,
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic [LINE_WIDTH-1:0]                rsp_data_o,
    input  logic                                 refill_valid_i,
    output logic                                 refill_ready_o,
    input  logic [AW-1:0]                        refill_addr_i,
    input  logic [WW-1:0]                        refill_way_i,
    input  logic [LINE_WIDTH-1:0]                refill_data_i,
    output logic [WAY_COUNT-1:0]                 ram_enable_o,
    output logic                                 ram_write_o,
    output logic [AW-1:0]                        ram_addr_o,
    output logic [LINE_WIDTH-1:0]                ram_wdata_o,
    input  logic [WAY_COUNT-1:0][LINE_WIDTH-1:0] ram_rdata_i
);
    localparam int unsigned SW = $clog2(MAX_STALL + 1);

    logic                  pend_q;
    logic [WW-1:0]         way_q;
    logic                  hold_valid_q;
    logic [LINE_WIDTH-1:0] hold_data_q;
    logic [SW-1:0]         stall_cnt_q;

    logic rsp_free, force_lk, lookup_fire, refill_fire;

    // The hold register takes priority over the live SRAM output. This keeps
    // a stalled line stable even if a refill rewrites the same SRAM entry.
    assign rsp_valid_o = pend_q | hold_valid_q;
    assign rsp_data_o  = hold_valid_q ? hold_data_q : ram_rdata_i[way_q];
    assign rsp_free    = !rsp_valid_o | rsp_ready_i;

    // Force only when the lookup could actually be issued.
    // Otherwise the refill would be blocked for nothing.
    assign force_lk       = lookup_valid_i & rsp_free & (stall_cnt_q == SW'(MAX_STALL));
    assign refill_ready_o = !rst_i & !force_lk;
    assign lookup_ready_o = !rst_i & rsp_free & (!refill_valid_i | force_lk);

    assign lookup_fire = lookup_valid_i & lookup_ready_o;
    assign refill_fire = refill_valid_i & refill_ready_o;
    assign ram_wdata_o = refill_data_i;

    // SRAM port mux: the ready terms make the two fires mutually exclusive.
    always_comb begin
        ram_enable_o = '0;
        ram_write_o  = 1'b0;
        ram_addr_o   = lookup_addr_i;
        if (refill_fire) begin
            ram_enable_o = WAY_COUNT'(1) << refill_way_i;
            ram_write_o  = 1'b1;
            ram_addr_o   = refill_addr_i;
        end else if (lookup_fire) begin
            ram_enable_o = WAY_COUNT'(1) << lookup_way_i;
        end
    end

    // Response tracking, hold capture and the starvation counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q       <= 1'b0;
            way_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            pend_q <= lookup_fire;
            if (lookup_fire) way_q <= lookup_way_i;

            // Stalled SRAM data is captured before the next access can change it.
            if (pend_q & !rsp_ready_i) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= ram_rdata_i[way_q];
            end else if (hold_valid_q & rsp_ready_i) begin
                hold_valid_q <= 1'b0;
            end

            if (lookup_fire) begin
                stall_cnt_q <= '0;
            end else if (lookup_valid_i & refill_fire & rsp_free &
                         (stall_cnt_q != SW'(MAX_STALL))) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_snitch_icache_data_ctrl.sv
// Scoreboard bench for snitch_icache_data_ctrl: a line-array reference model
// predicts every response, and a negedge monitor checks port behaviour.
module tb_snitch_icache_data_ctrl;
    localparam int WAYS = 4;
    localparam int LINES = 128;
    localparam int LW = 128;
    localparam int MS = 4;

    logic clk = 0;
    logic rst = 1;
    logic lookup_valid = 0, lookup_ready;
    logic [6:0] lookup_addr = '0;
    logic [1:0] lookup_way = '0;
    logic rsp_valid, rsp_ready = 0;
    logic [LW-1:0] rsp_data;
    logic refill_valid = 0, refill_ready;
    logic [6:0] refill_addr = '0;
    logic [1:0] refill_way = '0;
    logic [LW-1:0] refill_data = '0;
    logic [WAYS-1:0] ram_enable;
    logic ram_write;
    logic [6:0] ram_addr;
    logic [LW-1:0] ram_wdata;
    logic [WAYS-1:0][LW-1:0] ram_rdata = '0;

    int n_chk = 0, n_fail = 0;
    logic [LW-1:0] sram_mem [WAYS][LINES];
    logic [LW-1:0] ref_mem [WAYS][LINES];
    logic [LW-1:0] sb [$];
    logic prev_lf = 0, prev_stall = 0, lf, rf;
    logic [LW-1:0] prev_data = '0, exp_line;
    logic [WAYS-1:0] exp_en;

    snitch_icache_data_ctrl #(
        .WAY_COUNT(WAYS), .LINE_COUNT(LINES), .LINE_WIDTH(LW), .MAX_STALL(MS)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready),
        .lookup_addr_i(lookup_addr), .lookup_way_i(lookup_way),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .refill_valid_i(refill_valid), .refill_ready_o(refill_ready),
        .refill_addr_i(refill_addr), .refill_way_i(refill_way), .refill_data_i(refill_data),
        .ram_enable_o(ram_enable), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    // The SRAM output register follows any access, writes included.
    // A controller that failed to capture stalled data would therefore see it overwritten.
    always @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (ram_enable[w]) begin
                if (ram_write) begin
                    sram_mem[w][ram_addr] <= ram_wdata;
                    ram_rdata[w] <= ram_wdata;
                end else begin
                    ram_rdata[w] <= sram_mem[w][ram_addr];
                end
            end
        end
    end

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: port rules, scoreboard push on lookup fire, pop on response accept.
    always @(negedge clk) begin
        lf = lookup_valid & lookup_ready;
        rf = refill_valid & refill_ready;
        if (rst) begin
            check("rst_lookup_ready", lookup_ready, 0);
            check("rst_refill_ready", refill_ready, 0);
            check("rst_ram_enable", ram_enable, 0);
            sb.delete();
            prev_lf = 0;
            prev_stall = 0;
        end else begin
            if (prev_lf) check("rsp_latency", rsp_valid, 1);
            if (prev_stall) begin
                check("stall_valid", rsp_valid, 1);
                check("stall_data", rsp_data, prev_data);
            end
            check("fire_exclusive", lf & rf, 0);
            check("ram_wdata", ram_wdata, refill_data);
            exp_en = '0;
            if (rf) exp_en[refill_way] = 1'b1;
            else if (lf) exp_en[lookup_way] = 1'b1;
            check("ram_enable", ram_enable, exp_en);
            if (rf | lf) begin
                check("ram_write", ram_write, rf);
                check("ram_addr", ram_addr, rf ? refill_addr : lookup_addr);
            end
            if (lf) sb.push_back(ref_mem[lookup_way][lookup_addr]);
            if (rf) ref_mem[refill_way][refill_addr] = refill_data;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    exp_line = sb.pop_front();
                    check("rsp_data", rsp_data, exp_line);
                end
            end
            prev_lf = lf;
            prev_stall = rsp_valid & !rsp_ready;
            prev_data = rsp_data;
        end
    end

    task automatic do_refill(input int w, input int a, input logic [LW-1:0] d);
        int waits = 0;
        refill_valid = 1; refill_way = 2'(w); refill_addr = 7'(a); refill_data = d;
        while (1) begin
            @(negedge clk);
            if (refill_ready) break;
            waits++;
            if (waits > 20) begin check("refill_timeout", 1, 0); break; end
        end
        @(posedge clk); #1 refill_valid = 0;
    endtask

    task automatic do_lookup(input int w, input int a, output int waits);
        waits = 0;
        lookup_valid = 1; lookup_way = 2'(w); lookup_addr = 7'(a);
        while (1) begin
            @(negedge clk);
            if (lookup_ready) break;
            waits++;
            if (waits > 20) begin check("lookup_timeout", 1, 0); break; end
        end
        @(posedge clk); #1 lookup_valid = 0;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int waits;
        logic [LW-1:0] pat;
        for (int w = 0; w < WAYS; w++)
            for (int l = 0; l < LINES; l++) begin
                sram_mem[w][l] = '0;
                ref_mem[w][l] = '0;
            end

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_lookup_ready", lookup_ready, 1);
        check("reset_refill_ready", refill_ready, 1);
        @(posedge clk); #1;

        // Single read
        rsp_ready = 1;
        pat = {16{8'hA5}};
        do_refill(2, 5, pat);
        do_lookup(2, 5, waits);
        check("single_rsp_data", rsp_data, pat);
        @(posedge clk); #1;

        // Back-to-back lookups
        for (int a = 0; a < 8; a++) do_refill(a % 4, a, rnd_line());
        for (int a = 0; a < 8; a++) begin
            do_lookup(a % 4, a, waits);
            check("b2b_no_wait", waits, 0);
        end
        @(posedge clk); #1;

        // Way select: distinct line per way at one address
        for (int w = 0; w < WAYS; w++) do_refill(w, 20, {4{32'(w) + 32'h1000_0000}});
        for (int w = 0; w < WAYS; w++) do_lookup(w, 20, waits);
        @(posedge clk); #1;

        // Back-pressure with an overwriting refill to the same way/addr
        pat = rnd_line();
        do_refill(1, 9, pat);
        rsp_ready = 0;
        do_lookup(1, 9, waits);
        for (int k = 0; k < 3; k++) begin
            refill_valid = 1; refill_way = 1; refill_addr = 9; refill_data = {16{8'h0F}};
            @(negedge clk);
            check("bp_lookup_ready", lookup_ready, 0);
            check("bp_hold_data", rsp_data, pat);
            @(posedge clk); #1;
        end
        refill_valid = 0;
        @(negedge clk);
        check("bp_lookup_ready_idle", lookup_ready, 0);
        @(posedge clk); #1 rsp_ready = 1;
        @(posedge clk); #1;

        // Starvation: refills win MAX_STALL times, then the lookup is forced
        lookup_valid = 1; refill_valid = 1;
        for (int i = 0; i < 2 * (MS + 1); i++) begin
            lookup_addr = 7'($urandom_range(0, 15)); lookup_way = 2'($urandom);
            refill_addr = 7'($urandom_range(0, 15)); refill_way = 2'($urandom);
            refill_data = rnd_line();
            @(negedge clk);
            check("starve_lookup_ready", lookup_ready, (i % (MS + 1)) == MS);
            check("starve_refill_ready", refill_ready, (i % (MS + 1)) != MS);
            @(posedge clk); #1;
        end
        lookup_valid = 0; refill_valid = 0;
        @(posedge clk); #1;

        // Reset while a response sits in the hold register
        rsp_ready = 0;
        do_lookup(3, 7, waits);
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_valid", rsp_valid, 1);
        @(posedge clk); #1;
        rst = 1; lookup_valid = 1; refill_valid = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_drop_valid", rsp_valid, 0);
        @(posedge clk); #1;
        rst = 0; lookup_valid = 0; refill_valid = 0; rsp_ready = 1;
        @(negedge clk);
        check("post_rst_valid", rsp_valid, 0);
        @(posedge clk); #1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            lookup_valid = 1'($urandom);
            lookup_addr = 7'($urandom_range(0, 7)); lookup_way = 2'($urandom);
            refill_valid = ($urandom_range(0, 3) == 0);
            refill_addr = 7'($urandom_range(0, 7)); refill_way = 2'($urandom);
            refill_data = rnd_line();
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        lookup_valid = 0; refill_valid = 0; rsp_ready = 1;
        repeat (4) @(posedge clk);
        #1 check("drain_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
